// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: streams sequential words from a combinational
// instruction memory into a small FIFO, with redirect flush and halt.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t             buf_q [BUF_DEPTH];
  entry_t             head;
  logic [31:0]        fetch_pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign head      = buf_q[rd_ptr];
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;

  // A pop frees a slot in the same cycle, so a full buffer keeps streaming.
  always_comb begin
    pop  = out_valid & out_ready;
    push = ~redirect_valid & ~halt & ((count < CNT_W'(BUF_DEPTH)) | pop);
  end

  // Control state; redirect flushes everything and wins over push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage carries no reset; validity lives in count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr] <= {fetch_pc, imem_data};
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit (depth 2): per-cycle vector table
// plus a hand-written asynchronous reset sequence.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  // Memory word[i] = 0x1000_0000 + i, indexed by addr[11:2].
  assign imem_data = 32'h1000_0000 + {22'd0, imem_addr[11:2]};

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return 32'h1000_0000 + {22'd0, pc[11:2]};
  endfunction

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        h;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ea;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rv, input logic [31:0] rpc, input logic h,
                     input logic rdy, input logic ev, input logic [31:0] epc,
                     input logic [31:0] ea);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.h = h; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] ea);
    check32({tag, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
    check32({tag, "_addr"}, imem_addr, ea);
    if (ev) begin
      check32({tag, "_pc"}, out_pc, epc);
      check32({tag, "_inst"}, out_inst, exp_inst(epc));
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    out_ready      = 1'b1;

    // Expected outputs are those visible during the cycle the inputs are applied.
    // streaming
    add(0, 32'h0, 0, 1, 0, 32'h0,  32'h0);
    add(0, 32'h0, 0, 1, 1, 32'h0,  32'h4);
    add(0, 32'h0, 0, 1, 1, 32'h4,  32'h8);
    add(0, 32'h0, 0, 1, 1, 32'h8,  32'hC);
    // flush to 0, then backpressure for 5 cycles
    add(1, 32'h0, 0, 0, 1, 32'hC,  32'h10);
    add(0, 32'h0, 0, 0, 0, 32'h0,  32'h0);
    add(0, 32'h0, 0, 0, 1, 32'h0,  32'h4);
    add(0, 32'h0, 0, 0, 1, 32'h0,  32'h8);
    add(0, 32'h0, 0, 0, 1, 32'h0,  32'h8);
    add(0, 32'h0, 0, 0, 1, 32'h0,  32'h8);
    // release: full buffer with pop keeps pushing
    add(0, 32'h0, 0, 1, 1, 32'h0,  32'h8);
    add(0, 32'h0, 0, 1, 1, 32'h4,  32'hC);
    add(0, 32'h0, 0, 1, 1, 32'h8,  32'h10);
    // refill to full, then redirect to unaligned 0x103 while popping
    add(0, 32'h0,   0, 0, 1, 32'hC,   32'h14);
    add(1, 32'h103, 0, 1, 1, 32'hC,   32'h14);
    add(0, 32'h0,   0, 1, 0, 32'h0,   32'h100);
    add(0, 32'h0,   0, 1, 1, 32'h100, 32'h104);
    // PC wrap-around
    add(1, 32'hFFFF_FFF8, 0, 1, 1, 32'h104,       32'h108);
    add(0, 32'h0,         0, 1, 0, 32'h0,         32'hFFFF_FFF8);
    add(0, 32'h0,         0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    add(0, 32'h0,         0, 1, 1, 32'hFFFF_FFFC, 32'h0);
    add(0, 32'h0,         0, 1, 1, 32'h0,         32'h4);
    // halt with one entry buffered: drains, pc frozen, then resumes
    add(0, 32'h0, 1, 1, 1, 32'h4, 32'h8);
    add(0, 32'h0, 1, 1, 0, 32'h0, 32'h8);
    add(0, 32'h0, 1, 1, 0, 32'h0, 32'h8);
    add(0, 32'h0, 0, 1, 0, 32'h0, 32'h8);
    add(0, 32'h0, 0, 1, 1, 32'h8, 32'hC);
    // redirect wins over halt
    add(1, 32'h200, 1, 1, 1, 32'hC,   32'h10);
    add(0, 32'h0,   0, 1, 0, 32'h0,   32'h200);
    add(0, 32'h0,   0, 1, 1, 32'h200, 32'h204);

    @(negedge clk);
    #1 check_out("reset_state", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      halt           = vecs[i].h;
      out_ready      = vecs[i].rdy;
      #1 check_out($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ea);
      @(negedge clk);
    end

    // Fill to two entries (head 0x204, next 0x208), then reset between edges.
    redirect_valid = 1'b0;
    halt           = 1'b0;
    out_ready      = 1'b0;
    @(negedge clk);
    #1 check_out("full_before_reset", 1'b1, 32'h204, 32'h20C);
    @(posedge clk);
    #2 reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    halt           = 1'b1;
    #1 check_out("async_reset", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1 check_out("reset_ignores_redirect", 1'b0, 32'h0, 32'h0);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    out_ready      = 1'b1;
    @(negedge clk);
    #1 check_out("first_push_after_reset", 1'b1, 32'h0, 32'h4);
    @(negedge clk);
    #1 check_out("second_after_reset", 1'b1, 32'h4, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Parameter: BUF_DEPTH, 2, instruction buffer entries; legal values 2 or 4.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: imem_addr  output  32  byte address to instruction memory; memory returns the word at addr[11:2] combinationally.
REQ-006 Port: imem_data  input  32  instruction word at imem_addr, valid in the same cycle.
REQ-007 Port: redirect_valid  input  1  one-cycle request to change fetch PC (branch/jump).
REQ-008 Port: redirect_pc  input  32  new fetch address; sampled when redirect_valid=1.
REQ-009 Port: halt  input  1  level; suppresses new fetches while high.
REQ-010 Port: out_valid  output  1  buffer head holds a valid instruction.
REQ-011 Port: out_inst  output  32  instruction at buffer head.
REQ-012 Port: out_pc  output  32  PC of out_inst.
REQ-013 Port: out_ready  input  1  consumer accepts head when out_valid & out_ready.

Function
REQ-014 State: fetch_pc (32b), BUF_DEPTH-entry FIFO of {pc, inst}, read/write pointers, occupancy count 0..BUF_DEPTH.
REQ-015 imem_addr SHALL equal fetch_pc combinationally at all times, including during reset.
REQ-016 pop = out_valid & out_ready; head advances on that edge.
REQ-017 push = ~redirect_valid & ~halt & (count < BUF_DEPTH | pop); pushes {fetch_pc, imem_data}; fetch_pc <= fetch_pc + 4.
REQ-018 Full with simultaneous pop: push SHALL proceed the same cycle; count unchanged; no bubble.
REQ-019 Empty: out_valid=0; out_inst/out_pc don't-care; a push makes out_valid=1 the next cycle (1-cycle fetch latency).
REQ-020 Full and no pop: no push; fetch_pc holds; imem_addr stable.
REQ-021 Occupancy: count_next = count + push - pop; SHALL never exceed BUF_DEPTH nor underflow.
REQ-022 Redirect: on the edge, FIFO flushed (count=0, pointers reset), fetch_pc <= {redirect_pc[31:2], 2'b00}; no push that cycle; any pop that cycle is discarded as flushed.
REQ-023 Redirect takes priority over halt, push and pop.
REQ-024 Halt: no push; fetch_pc holds; pops continue normally until empty.
REQ-025 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
REQ-026 Pointers wrap modulo BUF_DEPTH.
REQ-027 Buffer order strictly FIFO; out_pc of consecutive pops without an intervening redirect differs by exactly 4.
REQ-028 out_inst/out_pc SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-029 On reset assertion, immediately and independent of clk: fetch_pc=RESET_PC, count=0, pointers=0, out_valid=0.
REQ-030 Reset mid-operation SHALL discard all buffered entries and ignore simultaneous redirect_valid/halt.
REQ-031 First push SHALL occur on the first rising edge after reset deasserts, if halt=0 and redirect_valid=0.
REQ-032 Buffer data storage needs no reset; only the valid/occupancy state does.

Verification
REQ-033 Streaming: memory word[i]=32'h1000_0000+i, out_ready=1 -> out_pc 0,4,8,... and out_inst 0x10000000, 0x10000001,... one per cycle after a 1-cycle latency.
REQ-034 Backpressure: out_ready=0 for 5 cycles -> count saturates at BUF_DEPTH, imem_addr holds at 8 (depth 2), head stays pc=0; out_ready=1 -> pcs 0,4,8 delivered in order, no gaps or duplicates.
REQ-035 Redirect while full: redirect_pc=32'h0000_0103 -> next cycle out_valid=0, imem_addr=32'h0000_0100; the following cycle out_pc=0x100.
REQ-036 Wrap-around: redirect to 32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Halt: halt=1 with 1 entry buffered, out_ready=1 -> entry drains, out_valid=0, fetch_pc frozen; halt=0 -> fetch resumes at the frozen pc.
REQ-038 Async reset: assert reset between clock edges with count=2 -> out_valid=0 and imem_addr=RESET_PC before the next edge.
